// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;
   localparam int CNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
      return N_REQ'(1) << i;
   endfunction

endpackage

// File: rtl/rr_prio_encoder_8x3.sv
// Rotating priority encoder: picks the first set bit of (req & mask) scanning
// upward from ptr with wrap-around.
module rr_prio_encoder_8x3
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic [N_REQ-1:0] mask,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [N_REQ-1:0]   masked;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [IDX_W-1:0]   sel;

   always_comb begin
      masked = req & mask;
      // rot[i] holds masked[(i + ptr) mod 8], so bit 0 is the highest priority
      dbl    = {masked, masked} >> ptr;
      rot    = dbl[N_REQ-1:0];
      found  = |rot;
      sel    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) sel = IDX_W'(i);
      end
      idx = sel + ptr;
   end

endmodule

// File: rtl/rr_arbiter_8x3.sv
// Round-robin arbiter for 8 requesters. A requester holds req high while it owns
// the resource; gnt stays asserted until req drops or the hold limit preempts it.
module rr_arbiter_8x3
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt,
   output state_e           dbg_state_o
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             preempt_q, preempt_d;

   logic [IDX_W-1:0] arb_ptr;
   logic [N_REQ-1:0] arb_mask;
   logic [IDX_W-1:0] win_idx;
   logic             win_found;
   logic             hold_limit;

   // While busy, any re-arbitration starts after the owner and excludes it.
   always_comb begin
      if (state_q == BUSY) begin
         arb_ptr  = idx_q + 3'd1;
         arb_mask = ~onehot(idx_q);
      end else begin
         arb_ptr  = ptr_q;
         arb_mask = '1;
      end
   end

   rr_prio_encoder_8x3 u_enc (
      .req   (req),
      .ptr   (arb_ptr),
      .mask  (arb_mask),
      .idx   (win_idx),
      .found (win_found)
   );

   assign hold_limit = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = BUSY;
               gnt_d   = onehot(win_idx);
               idx_d   = win_idx;
               valid_d = 1'b1;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (req[idx_q]) begin
               if (hold_limit) begin
                  cnt_d = '0;
                  if (win_found) begin
                     preempt_d = 1'b1;
                     ptr_d     = idx_q + 3'd1;
                     gnt_d     = onehot(win_idx);
                     idx_d     = win_idx;
                  end
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               ptr_d = idx_q + 3'd1;
               cnt_d = '0;
               if (win_found) begin
                  gnt_d = onehot(win_idx);
                  idx_d = win_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  idx_d   = '0;
                  valid_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         preempt_q <= preempt_d;
      end
   end

   assign gnt         = gnt_q;
   assign gnt_idx     = idx_q;
   assign gnt_valid   = valid_q;
   assign preempt     = preempt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_arbiter_8x3.sv
// Directed bench for rr_arbiter_8x3: default-limit instance plus a MAX_HOLD=4 instance.
module tb_rr_arbiter_8x3;
   import arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;
   state_e     dbg_state;

   logic       rst2_n = 1'b0;
   logic [7:0] req2 = 8'h00;
   logic [7:0] gnt2;
   logic [2:0] gnt2_idx;
   logic       gnt2_valid;
   logic       preempt2;
   state_e     dbg2_state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rr_arbiter_8x3 dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_idx(gnt_idx),
      .gnt_valid(gnt_valid), .preempt(preempt), .dbg_state_o(dbg_state)
   );

   rr_arbiter_8x3 #(.MAX_HOLD(4)) dut_h4 (
      .clk(clk), .rst_n(rst2_n), .req(req2), .gnt(gnt2), .gnt_idx(gnt2_idx),
      .gnt_valid(gnt2_valid), .preempt(preempt2), .dbg_state_o(dbg2_state)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      rst2_n = 1'b0;
      req    = 8'h00;
      req2   = 8'h00;
      tick();
      tick();
      rst_n  = 1'b1;
      rst2_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         tick();
         n_tests++;
         if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle cyc %0d: gnt=%h idx=%0d valid=%b pre=%b, want 00/0/0/0",
                     c, gnt, gnt_idx, gnt_valid, preempt);
         end
      end
   endtask

   task automatic test_single();
      req = 8'h08;
      tick();
      n_tests++;
      if (gnt !== 8'h08 || gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant: gnt=%h idx=%0d valid=%b, want 08/3/1", gnt, gnt_idx, gnt_valid);
      end
      req = 8'h00;
      tick();
      n_tests++;
      if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: gnt=%h idx=%0d valid=%b, want 00/0/0", gnt, gnt_idx, gnt_valid);
      end
      tick();
      req = 8'hFF;
      tick();
      n_tests++;
      if (gnt !== 8'h10 || gnt_idx !== 3'd4 || gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_next_ptr: gnt=%h idx=%0d, want 10/4", gnt, gnt_idx);
      end
   endtask

   task automatic test_rotation();
      int k;
      do_reset();
      req = 8'hFF;
      tick();
      for (int s = 0; s < 9; s++) begin
         k = s % 8;
         n_tests++;
         if (gnt !== (8'h01 << k) || gnt_idx !== 3'(k) || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rotation_first step %0d: gnt=%h idx=%0d valid=%b, want idx %0d",
                     s, gnt, gnt_idx, gnt_valid, k);
         end
         tick();
         n_tests++;
         if (gnt !== (8'h01 << k) || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rotation_hold step %0d: gnt=%h valid=%b, want idx %0d", s, gnt, gnt_valid, k);
         end
         req[k] = 1'b0;
         tick();
         req[k] = 1'b1;
      end
      req = 8'h00;
   endtask

   task automatic test_preempt();
      do_reset();
      req2 = 8'h04;
      tick();
      n_tests++;
      if (gnt2 !== 8'h04 || gnt2_idx !== 3'd2) begin
         n_fail++;
         $display("FAIL preempt_grant2: gnt=%h idx=%0d, want 04/2", gnt2, gnt2_idx);
      end
      tick();
      req2[5] = 1'b1;
      for (int c = 2; c <= 5; c++) begin
         if (c > 2) tick();
         n_tests++;
         if (gnt2 !== 8'h04 || preempt2 !== 1'b0) begin
            n_fail++;
            $display("FAIL preempt_hold cyc %0d: gnt=%h pre=%b, want 04/0", c, gnt2, preempt2);
         end
      end
      tick();
      n_tests++;
      if (gnt2 !== 8'h20 || gnt2_idx !== 3'd5 || preempt2 !== 1'b1) begin
         n_fail++;
         $display("FAIL preempt_switch: gnt=%h idx=%0d pre=%b, want 20/5/1", gnt2, gnt2_idx, preempt2);
      end
      tick();
      n_tests++;
      if (gnt2 !== 8'h20 || preempt2 !== 1'b0) begin
         n_fail++;
         $display("FAIL preempt_pulse_once: gnt=%h pre=%b, want 20/0", gnt2, preempt2);
      end
      req2 = 8'h00;
      tick();
      tick();
      req2 = 8'h04;
      tick();
      for (int c = 0; c < 20; c++) begin
         n_tests++;
         if (gnt2 !== 8'h04 || preempt2 !== 1'b0) begin
            n_fail++;
            $display("FAIL preempt_alone cyc %0d: gnt=%h pre=%b, want 04/0", c, gnt2, preempt2);
         end
         tick();
      end
      req2 = 8'h00;
   endtask

   task automatic test_wrap();
      do_reset();
      req = 8'h40;
      tick();
      n_tests++;
      if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
         n_fail++;
         $display("FAIL wrap_grant6: gnt=%h idx=%0d, want 40/6", gnt, gnt_idx);
      end
      req = 8'h00;
      tick();
      req = 8'h81;
      tick();
      n_tests++;
      if (gnt !== 8'h80 || gnt_idx !== 3'd7 || gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_grant7: gnt=%h idx=%0d, want 80/7", gnt, gnt_idx);
      end
      req = 8'h01;
      tick();
      n_tests++;
      if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_grant0: gnt=%h idx=%0d valid=%b, want 01/0/1", gnt, gnt_idx, gnt_valid);
      end
      req = 8'h00;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 8'h20;
      tick();
      n_tests++;
      if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
         n_fail++;
         $display("FAIL midrst_grant: gnt=%h idx=%0d, want 20/5", gnt, gnt_idx);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async_clear: gnt=%h idx=%0d valid=%b, want 00/0/0", gnt, gnt_idx, gnt_valid);
      end
      req = 8'h00;
      tick();
      rst_n = 1'b1;
      tick();
      req = 8'h21;
      tick();
      n_tests++;
      if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_regrant: gnt=%h idx=%0d, want 01/0", gnt, gnt_idx);
      end
      req = 8'h00;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_preempt();
      test_wrap();
      test_reset_mid_grant();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rr_arbiter_8x3.md
# rr_arbiter_8x3

Round-robin arbiter that shares one downstream resource among eight requesters. It produces a one-hot grant and the 3-bit encoded index of the current owner, and holds the grant until the owner releases. A hold-time limit prevents any single requester from starving the others. It sits in front of the shared datapath and drives its select lines from `gnt_idx`.

## Interface
Parameters:
- `MAX_HOLD`, 16: maximum consecutive grant cycles before forced rotation when others are waiting. 0 disables the limit. Legal range 0..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `req` in 8: request lines; `req[i]` is held high by requester i for as long as it wants or uses the resource.
- `gnt` out 8: one-hot grant; all zero when idle.
- `gnt_idx` out 3: binary index of the owner; 0 when idle.
- `gnt_valid` out 1: high while any grant is active.
- `preempt` out 1: one-cycle pulse on the cycle a grant is revoked by the hold limit.

## Operation
- All outputs are registered.
- Reset values: `gnt`=8'h00, `gnt_idx`=3'd0, `gnt_valid`=0, `preempt`=0, round-robin pointer `ptr`=3'd0, hold counter=0, state=IDLE.
- **States:**
  - IDLE: no owner. If `req`≠0, grant the first set bit found scanning from `ptr` upward with wrap (`ptr`, `ptr+1`, …, 7, 0, …, `ptr-1`), then go to BUSY. If `req`=0, stay in IDLE.
  - BUSY, owner k, owner still requesting (`req[k]`=1):
    - Keep the grant and increment the hold counter.
    - If `MAX_HOLD`≠0, the counter reaches `MAX_HOLD`, and any other request bit is set: revoke the grant, pulse `preempt`, set `ptr`=k+1 (mod 8), and re-arbitrate.
    - If no other request is pending at the limit: keep the grant and clear the counter.
  - BUSY, owner released (`req[k]`=0):
    - Set `ptr`=k+1 (mod 8).
    - Re-arbitrate the same cycle over the remaining requests, excluding k.
    - If a winner exists, grant it next cycle with no idle bubble (stay in BUSY, counter cleared). Otherwise go to IDLE.
- Re-arbitration after preemption excludes k for that one decision, so a different requester always wins.
- The pointer changes only on release or preemption. It never changes while in IDLE.
- `gnt` is always exactly one-hot or zero.
- `gnt_idx` matches `gnt` and reads 0 when `gnt_valid`=0.
- A request that drops before it is granted is simply ignored; there is no latching of requests.
- Pointer and index arithmetic is 3-bit, wrapping modulo 8 (7+1→0).
- The hold counter is 8 bits and saturates; it is never compared when `MAX_HOLD`=0.

## Timing
- Request to grant: `req[i]` sampled at edge n, so `gnt[i]` is high after edge n (visible in cycle n+1). Latency is 1 cycle from an idle arbiter.
- Release to next grant: owner drops `req` before edge n; the old grant clears and the new grant rises on the same edge n. Handover costs 1 cycle and leaves no gap.
- Preemption: the grant is lost after `MAX_HOLD`+1 cycles of ownership. `preempt` is high in the same cycle the new grant first appears.
- Simultaneous release and new requests: the new requests compete in that same decision.
- Async reset mid-grant: all outputs drop immediately to their reset values, independent of `clk`. The first grant after reset scans from index 0.

## Structure
- Shared package `arb_pkg`: `N_REQ`=8, `IDX_W`=3, state enum {IDLE, BUSY}, counter width constant.
- Sub-module `rr_prio_encoder_8x3`, combinational:
  - Inputs: `req[7:0]`, `ptr[2:0]`, `mask[7:0]`.
  - Outputs: `idx[2:0]`, `found`.
  - Function: rotate by `ptr`, fixed-priority encode, un-rotate.
- The top level holds the FSM, pointer, counter and output registers.

## Test plan
- **Reset / idle:** `rst_n`=0 then 1, `req`=0 → `gnt`=0, `gnt_idx`=0, `gnt_valid`=0 for 10 cycles.
- **Single request:** `req`=8'h08 → next cycle `gnt`=8'h08, `gnt_idx`=3; drop `req` → the following cycle `gnt`=0, and a later `req`=8'hFF is granted to index 4.
- **Rotation fairness:** `req`=8'hFF held by all; each owner releases after 2 cycles → grant order 0,1,2,…,7,0 with no idle cycles between grants.
- **Preemption:** `MAX_HOLD`=4, `req[2]` held forever, `req[5]` raised on cycle 2 → grant moves to 5 after index 2 has owned for 5 cycles, with `preempt` pulsing once. With `req[5]` absent, index 2 keeps the grant indefinitely.
- **Wrap-around:** pointer at 7 (after index 6 releases), `req`=8'h81 → grant index 7, then index 0 on release.
- **Reset mid-grant:** assert `rst_n`=0 asynchronously while `gnt`=8'h20 → outputs clear before the next clock edge. After release, `req`=8'h21 is granted to index 0.
